led_shift_out: RTL and testbench



---
 rtl/explorer_pkg.sv | 17 +
 rtl/led_shift_out_ser_phase_timer.sv | 42 ++++
 rtl/led_shift_out.sv | 125 ++++++++++++
 tb/tb_led_shift_out.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/explorer_pkg.sv
// explorer_pkg: constants shared by the LED serial-out stage.
// State encoding, default widths and counter-width helper.
package explorer_pkg;

    localparam int LED_W       = 8;
    localparam int CLK_DIV_DEF = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOW   = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_shift_out_ser_phase_timer.sv
// ser_phase_timer: counts CLK_DIV cycles per serial phase.
// phase_end marks the last cycle of a phase; last_next predicts it.
module ser_phase_timer
    import explorer_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic phase_end,
    output logic last_next
);

    localparam int DW = cnt_w(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_n;

    assign phase_end = run && (div_cnt == DIV_LAST);
    assign last_next = (div_n == DIV_LAST);

    // count up inside a phase, back to zero at its end or when idle
    always_comb begin
        div_n = div_cnt + 1'b1;
        if (restart || !run || phase_end) begin
            div_n = '0;
        end
    end

    // divider register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_n;
        end
    end

endmodule

// File: rtl/led_shift_out.sv
// led_shift_out: serialises the LED bus to a 74HC595-style register.
// Optional periodic re-send enabled by defining SER_REFRESH_EN.
module led_shift_out
    import explorer_pkg::*;
#(
    parameter int WIDTH          = LED_W,
    parameter int CLK_DIV        = CLK_DIV_DEF,
    parameter int REFRESH_CYCLES = 1 << 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_leds,
    output logic             out_ser_data,
    output logic             out_ser_clk,
    output logic             out_ser_latch,
    output logic             out_busy,
    output logic             out_done
);

    localparam int BW = cnt_w(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] last_sent;
    logic [BW-1:0]    bit_cnt;
    logic             dirty;
    logic             capture;
    logic             phase_end;
    logic             last_next;
    logic             refresh_hit;

    assign capture = (state == ST_IDLE)
                   && (dirty || (in_leds != last_sent));

    // MSB of the shift register is the serial data flop
    assign out_ser_data = sh[WIDTH-1];

    ser_phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .restart  (capture),
        .run      (state != ST_IDLE),
        .phase_end(phase_end),
        .last_next(last_next)
    );

    // next-state decode
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:  if (capture) state_n = ST_LOW;
            ST_LOW:   if (phase_end) state_n = ST_HIGH;
            ST_HIGH:  if (phase_end)
                          state_n = (bit_cnt == BIT_LAST)
                                  ? ST_LATCH : ST_LOW;
            ST_LATCH: if (phase_end) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // state, datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            sh            <= '0;
            last_sent     <= '0;
            bit_cnt       <= '0;
            dirty         <= 1'b1;
            out_ser_clk   <= 1'b0;
            out_ser_latch <= 1'b0;
            out_busy      <= 1'b0;
            out_done      <= 1'b0;
        end else begin
            state         <= state_n;
            out_ser_clk   <= (state_n == ST_HIGH);
            out_ser_latch <= (state_n == ST_LATCH);
            out_busy      <= (state_n != ST_IDLE);
            out_done      <= (state_n == ST_LATCH) && last_next;
            if (capture) begin
                sh        <= in_leds;
                last_sent <= in_leds;
                dirty     <= 1'b0;
                bit_cnt   <= '0;
            end else begin
                if (refresh_hit) begin
                    dirty <= 1'b1;
                end
                if ((state == ST_HIGH) && phase_end
                    && (bit_cnt != BIT_LAST)) begin
                    sh      <= sh << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

`ifdef SER_REFRESH_EN
    localparam int RW = cnt_w(REFRESH_CYCLES);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

    logic [RW-1:0] idle_cnt;

    assign refresh_hit = (state == ST_IDLE) && !capture
                       && (idle_cnt == REF_LAST);

    // unchanged-idle counter; saturates until the forced re-send starts
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (capture) begin
            idle_cnt <= '0;
        end else if ((state == ST_IDLE) && (idle_cnt != REF_LAST)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // no periodic refresh in this build; always low
    assign refresh_hit = (REFRESH_CYCLES < 0);
`endif

endmodule

// File: tb/tb_led_shift_out.sv
// tb_led_shift_out: random and directed stimulus against a cycle model.
// Two instances (CLK_DIV=2 and CLK_DIV=1) share inputs.
module tb_led_shift_out;

    localparam int R = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_leds = 8'hA5;
    wire  [1:0] dat, sck, lat, bsy, dn;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    led_shift_out #(.WIDTH(8), .CLK_DIV(2), .REFRESH_CYCLES(R)) u0 (
        .clock(clock), .reset(reset), .in_leds(in_leds),
        .out_ser_data(dat[0]), .out_ser_clk(sck[0]),
        .out_ser_latch(lat[0]), .out_busy(bsy[0]), .out_done(dn[0])
    );

    led_shift_out #(.WIDTH(8), .CLK_DIV(1), .REFRESH_CYCLES(R)) u1 (
        .clock(clock), .reset(reset), .in_leds(in_leds),
        .out_ser_data(dat[1]), .out_ser_clk(sck[1]),
        .out_ser_latch(lat[1]), .out_busy(bsy[1]), .out_done(dn[1])
    );

    function automatic int cdiv(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int tlen(int i);
        return 2 * cdiv(i) * 8 + cdiv(i);
    endfunction

    // expected {data, clk, latch, busy, done} at cycle t of a transfer
    function automatic logic [4:0] expv(int c, int t, logic [7:0] v);
        int ph;
        logic [4:0] r;
        if (t == 0) return 5'b0;
        ph = (t - 1) / c;
        r = 5'b00010;
        if (ph < 16) begin
            r[4] = v[7 - ph / 2];
            r[3] = (ph % 2) == 1;
        end else begin
            r[2] = 1'b1;
            r[0] = (t == 2 * c * 8 + c);
        end
        return r;
    endfunction

    // transfer-level model: m_t = cycle index in transfer (0 = idle)
    int         m_t[2];
    logic [7:0] m_val[2];
    logic [7:0] m_last[2];
    bit         m_dirty[2];
    int         m_idle[2];

    always @(posedge clock or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_t[i] = 0; m_val[i] = 0; m_last[i] = 0;
                m_dirty[i] = 1; m_idle[i] = 0;
            end else if (m_t[i] != 0) begin
                m_t[i] = (m_t[i] == tlen(i)) ? 0 : m_t[i] + 1;
            end else if (m_dirty[i] || in_leds != m_last[i]) begin
                m_val[i] = in_leds; m_last[i] = in_leds;
                m_dirty[i] = 0; m_idle[i] = 0; m_t[i] = 1;
            end
`ifdef SER_REFRESH_EN
            else if (m_idle[i] == R - 1) m_dirty[i] = 1;
            else m_idle[i]++;
`endif
        end
    end

    // monitor state
    logic [7:0] sent0[$];
    logic [7:0] sent1[$];
    logic [7:0] shv[2];
    logic       p_sck[2], p_lat[2], p_bsy[2];
    int rises[2], r_tr[2], lr_tr[2];
    int b_len[2], l_len[2], d_cnt[2];
    int lb_len[2], ll_len[2], ld_cnt[2];
    logic [4:0] got, exv, msk;

    // per-cycle compare plus waveform monitor
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            got = {dat[i], sck[i], lat[i], bsy[i], dn[i]};
            if (!reset) begin
                exv = 5'b0; msk = 5'b11111;
            end else begin
                exv = expv(cdiv(i), m_t[i], m_val[i]);
                msk = (m_t[i] > 0 && (m_t[i] - 1) / cdiv(i) < 16)
                    ? 5'b11111 : 5'b01111;
            end
            checks++;
            if (((got ^ exv) & msk) != 5'b0) begin
                errors++;
                $display("FAIL cycle u%0d t=%0d got %b exp %b",
                         i, m_t[i], got, exv);
            end
            if (!reset) begin
                p_sck[i] = 0; p_lat[i] = 0; p_bsy[i] = 0; shv[i] = 0;
            end else begin
                if (bsy[i] && !p_bsy[i]) begin
                    b_len[i] = 0; l_len[i] = 0; d_cnt[i] = 0; r_tr[i] = 0;
                end
                if (bsy[i]) b_len[i]++;
                if (lat[i]) l_len[i]++;
                if (dn[i]) d_cnt[i]++;
                if (sck[i] && !p_sck[i]) begin
                    shv[i] = {shv[i][6:0], dat[i]};
                    rises[i]++; r_tr[i]++;
                end
                if (lat[i] && !p_lat[i]) begin
                    if (i == 0) sent0.push_back(shv[i]);
                    else sent1.push_back(shv[i]);
                end
                if (!bsy[i] && p_bsy[i]) begin
                    lb_len[i] = b_len[i]; ll_len[i] = l_len[i];
                    ld_cnt[i] = d_cnt[i]; lr_tr[i] = r_tr[i];
                end
                p_sck[i] = sck[i]; p_lat[i] = lat[i]; p_bsy[i] = bsy[i];
            end
        end
    end

    function automatic int nsent(int i);
        return (i == 0) ? sent0.size() : sent1.size();
    endfunction

    function automatic int last_word(int i);
        if (i == 0) return (sent0.size() > 0) ? int'(sent0[$]) : -1;
        return (sent1.size() > 0) ? int'(sent1[$]) : -1;
    endfunction

    function automatic int count_val(int i, int from, logic [7:0] v);
        int n = 0;
        for (int k = from; k < nsent(i); k++) begin
            if (i == 0 && sent0[k] == v) n++;
            if (i == 1 && sent1[k] == v) n++;
        end
        return n;
    endfunction

    task automatic chk(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, actual, expected);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bsy != 2'b00 && n < 200) begin
            @(negedge clock); n++;
        end
        chk("idle_timeout", int'(bsy), 0);
    endtask

    int n0, n1, r0, r1, k;

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outs", int'({dat, sck, lat, bsy, dn}), 0);
        #1 reset = 1'b1;
        repeat (40) @(negedge clock);
        chk("a5_word0", last_word(0), 'hA5);
        chk("a5_busy0", lb_len[0], 34);
        chk("a5_latch0", ll_len[0], 2);
        chk("a5_done0", ld_cnt[0], 1);
        chk("a5_rises0", lr_tr[0], 8);
        chk("a5_busy1", lb_len[1], 17);
        chk("a5_word1", last_word(1), 'hA5);

        r0 = rises[0]; r1 = rises[1];
        repeat (500) @(negedge clock);
`ifndef SER_REFRESH_EN
        chk("quiet_rises0", rises[0] - r0, 0);
        chk("quiet_rises1", rises[1] - r1, 0);
        chk("quiet_words0", nsent(0), 1);
`else
        chk("refresh_seen0", int'(rises[0] > r0), 1);
`endif

        wait_idle();
        n0 = nsent(0); n1 = nsent(1);
        #1 in_leds = 8'h00;
        repeat (5) @(negedge clock);
        #1 in_leds = 8'h01;
        repeat (5) @(negedge clock);
        #1 in_leds = 8'h02;
        repeat (80) @(negedge clock);
        chk("drop01_u0", count_val(0, n0, 8'h01), 0);
        chk("drop01_u1", count_val(1, n1, 8'h01), 0);
        chk("last02_u0", last_word(0), 'h02);
        chk("last02_u1", last_word(1), 'h02);

        wait_idle();
        #1 in_leds = 8'h5A;
        k = 0;
        while (!bsy[0] && k < 10) begin
            @(negedge clock); k++;
        end
        chk("start_5a", int'(bsy[0]), 1);
        repeat (14) @(negedge clock);
        chk("pre_rst_clk0", int'(sck[0]), 1);
        chk("pre_rst_dat0", int'(dat[0]), 1);
        #2 reset = 1'b0;
        #1 chk("async_rst0", int'({dat[0], sck[0], lat[0], bsy[0]}), 0);
        repeat (3) @(negedge clock);
        #1 reset = 1'b1;
        repeat (80) @(negedge clock);
        chk("resend_5a0", last_word(0), 'h5A);
        chk("resend_busy0", lb_len[0], 34);

        wait_idle();
        #1 in_leds = 8'hFF;
        repeat (80) @(negedge clock);
        chk("ff_busy1", lb_len[1], 17);
        chk("ff_rises1", lr_tr[1], 8);
        chk("ff_word1", last_word(1), 'hFF);

        for (int j = 0; j < 40; j++) begin
            #1 if ($urandom_range(0, 3) != 0) in_leds = 8'($urandom);
            repeat ($urandom_range(1, 60)) @(negedge clock);
        end
        repeat (100) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
